// File: rtl/efuse_pkg.sv
// Shared types and default macro timing for the efuse read and write sequencers.
package efuse_pkg;

  localparam int EFUSE_AW    = 8;
  localparam int EFUSE_DW    = 8;
  localparam int EFUSE_T_SU  = 2;
  localparam int EFUSE_T_AEN = 4;
  localparam int EFUSE_T_HLD = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } efuse_rd_state_e;

endpackage

// File: rtl/efuse_phase_cnt.sv
// Loadable down-counter timing one macro phase; tc_o marks the last cycle of the phase.
module efuse_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Load value is (phase length - 1), so the counter parks at zero on the final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntOne;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/efuse_read_ctrl.sv
// Efuse read sequencer: walks a byte range through SETUP/STROBE/HOLD macro timing
// and returns each captured byte on a one-cycle strobe.
module efuse_read_ctrl
  import efuse_pkg::*;
#(
  parameter int T_SU  = EFUSE_T_SU,
  parameter int T_AEN = EFUSE_T_AEN,
  parameter int T_HLD = EFUSE_T_HLD,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_start,
  input  logic [EFUSE_AW-1:0] read_base,
  input  logic [EFUSE_AW-1:0] read_len,
  input  logic                rg_efuse_reg_mode,
  input  logic                busy_write,
  output logic                read_pgmen,
  output logic                read_rden,
  output logic                read_aen,
  output logic [EFUSE_AW-1:0] read_addr,
  input  logic [EFUSE_DW-1:0] read_rdata,
  output logic                busy_read,
  output logic                byte_vld,
  output logic [EFUSE_AW-1:0] byte_addr,
  output logic [EFUSE_DW-1:0] byte_data,
  output logic                read_done,
  output logic                read_abort,
  output logic                read_err
);

  localparam logic [CNT_W-1:0]    SuLoad  = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0]    AenLoad = CNT_W'(T_AEN - 1);
  localparam logic [CNT_W-1:0]    HldLoad = CNT_W'(T_HLD - 1);
  localparam logic [EFUSE_AW-1:0] AddrOne = EFUSE_AW'(1);

  efuse_rd_state_e     state_q;
  logic [EFUSE_AW-1:0] addr_q;
  logic [EFUSE_AW:0]   rem_q;
  logic                rden_q;
  logic                aen_q;
  logic                busy_q;
  logic                byte_vld_q;
  logic [EFUSE_AW-1:0] byte_addr_q;
  logic [EFUSE_DW-1:0] byte_data_q;
  logic                done_q;
  logic                abort_q;
  logic                err_q;

  logic             cnt_load_d;
  logic [CNT_W-1:0] cnt_val_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             accept;
  logic             active;
  logic             hold_first;

  assign accept     = read_start && !rg_efuse_reg_mode && !busy_write && (read_len != '0);
  assign active     = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign hold_first = (state_q == HOLD) && (cnt == HldLoad);

  efuse_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load_d),
    .load_val_i(cnt_val_d),
    .cnt_o     (cnt),
    .tc_o      (cnt_tc)
  );

  // Arm the phase counter on every transition into a timed phase.
  always_comb begin
    cnt_load_d = 1'b0;
    cnt_val_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_load_d = 1'b1;
          cnt_val_d  = SuLoad;
        end
      end
      SETUP: begin
        if (cnt_tc) begin
          cnt_load_d = 1'b1;
          cnt_val_d  = AenLoad;
        end
      end
      STROBE: begin
        if (cnt_tc) begin
          cnt_load_d = 1'b1;
          cnt_val_d  = HldLoad;
        end
      end
      HOLD: begin
        if (cnt_tc && (rem_q > 9'd1)) begin
          cnt_load_d = 1'b1;
          cnt_val_d  = SuLoad;
        end
      end
      default: begin
      end
    endcase
  end

  // Register mode takes the macro back immediately; a byte not yet captured is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rden_q      <= 1'b0;
      aen_q       <= 1'b0;
      busy_q      <= 1'b0;
      byte_vld_q  <= 1'b0;
      byte_addr_q <= '0;
      byte_data_q <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      if (active && rg_efuse_reg_mode) begin
        state_q <= DONE;
        rden_q  <= 1'b0;
        aen_q   <= 1'b0;
        done_q  <= 1'b1;
        abort_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (read_start) begin
              if (rg_efuse_reg_mode || busy_write) begin
                err_q <= 1'b1;
              end else if (read_len == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= SETUP;
                addr_q  <= read_base;
                rem_q   <= {1'b0, read_len};
                rden_q  <= 1'b1;
                busy_q  <= 1'b1;
              end
            end
          end
          SETUP: begin
            if (cnt_tc) begin
              state_q <= STROBE;
              aen_q   <= 1'b1;
            end
          end
          STROBE: begin
            if (cnt_tc) begin
              state_q <= HOLD;
              aen_q   <= 1'b0;
            end
          end
          HOLD: begin
            // The mux delays aen by a cycle, so data is still driven in the first HOLD cycle.
            if (hold_first) begin
              byte_vld_q  <= 1'b1;
              byte_addr_q <= addr_q;
              byte_data_q <= read_rdata;
            end
            if (cnt_tc) begin
              if (rem_q > 9'd1) begin
                state_q <= SETUP;
                addr_q  <= addr_q + AddrOne;
                rem_q   <= rem_q - 9'd1;
              end else begin
                state_q <= DONE;
                rden_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign read_pgmen = 1'b0;
  assign read_rden  = rden_q;
  assign read_aen   = aen_q;
  assign read_addr  = addr_q;
  assign busy_read  = busy_q;
  assign byte_vld   = byte_vld_q;
  assign byte_addr  = byte_addr_q;
  assign byte_data  = byte_data_q;
  assign read_done  = done_q;
  assign read_abort = abort_q;
  assign read_err   = err_q;

endmodule
